// File: rtl/aurora_bist_sequencer.sv
// Sequences one PRBS BIST run on the Aurora link MAC: arm, lock, run, evaluate, drain, report.
// All MAC-facing controls and status outputs are registered from the next-state decode.
module aurora_bist_sequencer #(
  parameter int unsigned LOCK_TIMEOUT = 4096,
  parameter int unsigned RUN_CYCLES   = 512,
  parameter int unsigned DRAIN_CYCLES = 256,
  parameter int unsigned MIN_SAMPS    = 256,
  parameter int unsigned CNT_W        = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [5:0]       rate,
  input  logic             remote_loop,
  input  logic             channel_up,
  input  logic             bist_locked,
  input  logic [CNT_W-1:0] bist_samps,
  input  logic [CNT_W-1:0] bist_errors,
  output logic             bist_gen_en,
  output logic             bist_checker_en,
  output logic [5:0]       bist_gen_rate,
  output logic             bist_loopback_en,
  output logic             busy,
  output logic             done,
  output logic [2:0]       result,
  output logic [CNT_W-1:0] samps_latched,
  output logic [CNT_W-1:0] errors_latched,
  output logic [15:0]      run_count
);

  localparam int unsigned MAX_RL  = (LOCK_TIMEOUT > RUN_CYCLES) ? LOCK_TIMEOUT : RUN_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_RL > DRAIN_CYCLES) ? MAX_RL : DRAIN_CYCLES;
  localparam int unsigned TMR_W   = $clog2(MAX_CYC) + 1;

  localparam logic [2:0] RES_PASS      = 3'd0;
  localparam logic [2:0] RES_LOCK_TO   = 3'd1;
  localparam logic [2:0] RES_LOW_SAMPS = 3'd2;
  localparam logic [2:0] RES_BIT_ERR   = 3'd3;
  localparam logic [2:0] RES_LINK_DOWN = 3'd4;
  localparam logic [2:0] RES_ABORTED   = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_WAIT_LOCK, S_RUN, S_EVAL, S_DRAIN, S_FINISH
  } state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [2:0]         result_d;
  logic [5:0]         rate_d;
  logic               loop_d;
  logic [CNT_W-1:0]   samps_d, errors_d;
  logic [15:0]        run_count_d;

  // Next-state, result and capture logic
  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q + TMR_W'(1);
    result_d    = result;
    rate_d      = bist_gen_rate;
    loop_d      = bist_loopback_en;
    samps_d     = samps_latched;
    errors_d    = errors_latched;
    run_count_d = run_count;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (channel_up) begin
            state_d  = S_ARM;
            rate_d   = rate;
            loop_d   = remote_loop;
            result_d = RES_PASS;
          end else begin
            state_d  = S_FINISH;
            result_d = RES_LINK_DOWN;
          end
        end
      end
      S_ARM: state_d = S_WAIT_LOCK;
      S_WAIT_LOCK: begin
        if (bist_locked) begin
          state_d = S_RUN;
        end else if (tmr_q == TMR_W'(LOCK_TIMEOUT - 1)) begin
          state_d  = S_DRAIN;
          result_d = RES_LOCK_TO;
        end
      end
      S_RUN: begin
        if (tmr_q == TMR_W'(RUN_CYCLES - 1)) state_d = S_EVAL;
      end
      S_EVAL: begin
        samps_d  = bist_samps;
        errors_d = bist_errors;
        if (bist_errors != '0)                      result_d = RES_BIT_ERR;
        else if (bist_samps <= CNT_W'(MIN_SAMPS))   result_d = RES_LOW_SAMPS;
        else                                        result_d = RES_PASS;
        state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (tmr_q == TMR_W'(DRAIN_CYCLES - 1)) state_d = S_FINISH;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Link loss beats abort; an abort during drain leaves the latched result alone
    if (state_q inside {S_ARM, S_WAIT_LOCK, S_RUN, S_EVAL, S_DRAIN}) begin
      if (!channel_up) begin
        state_d  = S_FINISH;
        result_d = RES_LINK_DOWN;
        samps_d  = samps_latched;
        errors_d = errors_latched;
      end else if (abort && state_q != S_DRAIN) begin
        state_d  = S_DRAIN;
        result_d = RES_ABORTED;
        samps_d  = samps_latched;
        errors_d = errors_latched;
      end
    end

    if (state_d != state_q || state_q == S_IDLE) tmr_d = '0;
    if (state_d == S_FINISH || state_d == S_IDLE) loop_d = 1'b0;
    if (state_d == S_FINISH && run_count != 16'hFFFF) run_count_d = run_count + 16'd1;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      tmr_q            <= '0;
      bist_gen_en      <= 1'b0;
      bist_checker_en  <= 1'b0;
      bist_gen_rate    <= '0;
      bist_loopback_en <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      result           <= '0;
      samps_latched    <= '0;
      errors_latched   <= '0;
      run_count        <= '0;
    end else begin
      state_q          <= state_d;
      tmr_q            <= tmr_d;
      bist_gen_en      <= (state_d inside {S_WAIT_LOCK, S_RUN, S_EVAL});
      bist_checker_en  <= (state_d inside {S_WAIT_LOCK, S_RUN, S_EVAL, S_DRAIN});
      bist_gen_rate    <= rate_d;
      bist_loopback_en <= loop_d;
      busy             <= (state_d != S_IDLE);
      done             <= (state_d == S_FINISH);
      result           <= result_d;
      samps_latched    <= samps_d;
      errors_latched   <= errors_d;
      run_count        <= run_count_d;
    end
  end

endmodule

// File: tb/tb_aurora_bist_sequencer.sv
// Directed bench for aurora_bist_sequencer: a per-cycle expected timeline is planned from
// each run's phase lengths and checked against the DUT on every falling edge.
module tb_aurora_bist_sequencer;

  localparam int unsigned CNT_W = 48;
  localparam int unsigned LT    = 32;
  localparam int unsigned RC    = 16;
  localparam int unsigned DC    = 8;
  localparam int unsigned MS    = 8;
  localparam int          N     = 1024;

  logic             clk = 1'b0;
  logic             rst_n, start, abort, remote_loop, channel_up, bist_locked;
  logic [5:0]       rate;
  logic [CNT_W-1:0] bist_samps, bist_errors;
  logic             bist_gen_en, bist_checker_en, bist_loopback_en, busy, done;
  logic [5:0]       bist_gen_rate;
  logic [2:0]       result;
  logic [CNT_W-1:0] samps_latched, errors_latched;
  logic [15:0]      run_count;

  aurora_bist_sequencer #(
    .LOCK_TIMEOUT(LT), .RUN_CYCLES(RC), .DRAIN_CYCLES(DC), .MIN_SAMPS(MS), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .rate(rate),
    .remote_loop(remote_loop), .channel_up(channel_up), .bist_locked(bist_locked),
    .bist_samps(bist_samps), .bist_errors(bist_errors),
    .bist_gen_en(bist_gen_en), .bist_checker_en(bist_checker_en),
    .bist_gen_rate(bist_gen_rate), .bist_loopback_en(bist_loopback_en),
    .busy(busy), .done(done), .result(result), .samps_latched(samps_latched),
    .errors_latched(errors_latched), .run_count(run_count)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;
  int cyc   = 0;
  bit chk_on = 1'b0;
  int gen_tot = 0, chkr_tot = 0, done_tot = 0;
  int m_rc = 0;

  logic             e_gen[N], e_chkr[N], e_loop[N], e_busy[N], e_done[N];
  logic [2:0]       e_res[N];
  logic [5:0]       e_rate[N];
  logic [15:0]      e_rc[N];
  logic [CNT_W-1:0] e_samps[N], e_errs[N];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  // Per-cycle comparison against the planned timeline
  always @(negedge clk) begin
    if (chk_on) begin
      if (cyc < N) begin
        check("gen_en",    64'(bist_gen_en),      64'(e_gen[cyc]));
        check("checker_en",64'(bist_checker_en),  64'(e_chkr[cyc]));
        check("loopback",  64'(bist_loopback_en), 64'(e_loop[cyc]));
        check("busy",      64'(busy),             64'(e_busy[cyc]));
        check("done",      64'(done),             64'(e_done[cyc]));
        check("result",    64'(result),           64'(e_res[cyc]));
        check("gen_rate",  64'(bist_gen_rate),    64'(e_rate[cyc]));
        check("run_count", 64'(run_count),        64'(e_rc[cyc]));
        check("samps_lat", 64'(samps_latched),    64'(e_samps[cyc]));
        check("errs_lat",  64'(errors_latched),   64'(e_errs[cyc]));
      end else begin
        check("timeline_overrun", 64'(cyc), 64'(N - 1));
      end
      gen_tot  += int'(bist_gen_en);
      chkr_tot += int'(bist_checker_en);
      done_tot += int'(done);
    end
  end

  task automatic span(input int which, input int a, input int b);
    for (int i = a; i <= b && i < N; i++) begin
      case (which)
        0: e_gen[i]  = 1'b1;
        1: e_chkr[i] = 1'b1;
        2: e_loop[i] = 1'b1;
        3: e_busy[i] = 1'b1;
        default: e_done[i] = 1'b1;
      endcase
    end
  endtask

  task automatic hold(input int which, input int from, input logic [63:0] v);
    for (int i = from; i < N; i++) begin
      case (which)
        0: e_res[i]   = v[2:0];
        1: e_rate[i]  = v[5:0];
        2: e_rc[i]    = v[15:0];
        3: e_samps[i] = v[CNT_W-1:0];
        default: e_errs[i] = v[CNT_W-1:0];
      endcase
    end
  endtask

  task automatic clear_from(input int from);
    for (int i = from; i < N; i++) begin
      e_gen[i] = 0; e_chkr[i] = 0; e_loop[i] = 0; e_busy[i] = 0; e_done[i] = 0;
      e_res[i] = 0; e_rate[i] = 0; e_rc[i] = 0; e_samps[i] = 0; e_errs[i] = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic finish_run(input int f);
    if (m_rc < 65535) m_rc++;
    span(3, f, f);
    span(4, f, f);
    hold(2, f, 64'(m_rc));
  endtask

  // kind 0: lock after wait_c WAIT_LOCK cycles, 1: no lock.
  // ev 0: none, 1: link drop at RUN offset, 2: abort at RUN offset, 3: reset at DRAIN offset.
  task automatic do_run(input int kind, input int wait_c, input int ev, input int ev_off,
                        input int samps, input int errs, input logic [5:0] rate_v,
                        input logic loop_v, input bit sec_start);
    int t0, w, r, d, f, x, last, res;
    t0 = cyc;
    w  = t0 + 2;
    x  = -1;
    hold(1, t0 + 1, 64'(rate_v));
    hold(0, t0 + 1, 64'd0);
    if (kind == 1) begin
      d = w + LT;
      f = d + DC;
      span(0, w, d - 1);
      span(1, w, f - 1);
      hold(0, d, 64'd1);
    end else begin
      r = w + wait_c;
      if (ev == 1) begin
        x = r + ev_off;
        f = x + 1;
        span(0, w, x);
        span(1, w, x);
        hold(0, f, 64'd4);
      end else if (ev == 2) begin
        x = r + ev_off;
        d = x + 1;
        f = d + DC;
        span(0, w, x);
        span(1, w, f - 1);
        hold(0, d, 64'd5);
      end else begin
        d = r + RC + 1;
        f = d + DC;
        res = (errs != 0) ? 3 : (samps <= int'(MS)) ? 2 : 0;
        span(0, w, d - 1);
        span(1, w, f - 1);
        hold(0, d, 64'(res));
        hold(3, d, 64'(samps));
        hold(4, d, 64'(errs));
      end
    end
    if (loop_v) span(2, t0 + 1, f - 1);
    span(3, t0 + 1, f - 1);
    finish_run(f);
    last = f;
    if (ev == 3) begin
      x = d + ev_off;
      clear_from(x + 1);
      m_rc = 0;
      last = x + 1;
    end

    while (cyc < last) begin
      start       = (cyc == t0) || (sec_start && cyc == w + 2);
      rate        = rate_v;
      remote_loop = loop_v;
      bist_samps  = CNT_W'(samps);
      bist_errors = CNT_W'(errs);
      bist_locked = (kind == 0) && (cyc >= w + wait_c - 1);
      channel_up  = !(ev == 1 && cyc == x);
      abort       = (ev == 2 && cyc == x);
      rst_n       = !(ev == 3 && cyc == x);
      step();
    end
    start = 0; abort = 0; bist_locked = 0; channel_up = 1; rst_n = 1;
    step();
    step();
  endtask

  task automatic do_nolink(input logic [5:0] rate_v);
    int t0;
    t0 = cyc;
    hold(0, t0 + 1, 64'd4);
    finish_run(t0 + 1);
    channel_up = 0; start = 1; rate = rate_v;
    step();
    start = 0; channel_up = 1;
    step();
    step();
  endtask

  int g0, c0, d0;

  initial begin
    rst_n = 0; start = 0; abort = 0; rate = '0; remote_loop = 0; channel_up = 1;
    bist_locked = 0; bist_samps = '0; bist_errors = '0;
    clear_from(0);
    step();
    chk_on = 1'b1;
    step();
    step();
    rst_n = 1;
    step();
    check("reset_result", 64'(result), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);

    // Nominal pass
    g0 = gen_tot; c0 = chkr_tot; d0 = done_tot;
    do_run(0, 5, 0, 0, 100, 0, 6'd60, 1'b1, 1'b0);
    check("nom_gen_cycles", 64'(gen_tot - g0), 64'd22);
    check("nom_chk_cycles", 64'(chkr_tot - c0), 64'd30);
    check("nom_done_pulses", 64'(done_tot - d0), 64'd1);
    check("nom_result", 64'(result), 64'd0);
    check("nom_samps", 64'(samps_latched), 64'd100);
    check("nom_run_count", 64'(run_count), 64'd1);

    // Lock timeout
    g0 = gen_tot; c0 = chkr_tot;
    do_run(1, 0, 0, 0, 0, 0, 6'd5, 1'b0, 1'b0);
    check("to_gen_cycles", 64'(gen_tot - g0), 64'd32);
    check("to_chk_cycles", 64'(chkr_tot - c0), 64'd40);
    check("to_result", 64'(result), 64'd1);

    // Evaluation priority and the MIN_SAMPS boundary
    do_run(0, 3, 0, 0, 2, 3, 6'd11, 1'b0, 1'b0);
    check("err_result", 64'(result), 64'd3);
    do_run(0, 3, 0, 0, 8, 0, 6'd12, 1'b1, 1'b0);
    check("low_result", 64'(result), 64'd2);
    do_run(0, 3, 0, 0, 9, 0, 6'd13, 1'b0, 1'b0);
    check("min1_result", 64'(result), 64'd0);

    // Link drop mid-RUN
    d0 = done_tot;
    do_run(0, 2, 1, 5, 50, 0, 6'd20, 1'b1, 1'b0);
    check("drop_result", 64'(result), 64'd4);
    check("drop_done", 64'(done_tot - d0), 64'd1);

    // Start with link down
    g0 = gen_tot; c0 = chkr_tot;
    do_nolink(6'd7);
    check("nolink_result", 64'(result), 64'd4);
    check("nolink_gen", 64'(gen_tot - g0 + chkr_tot - c0), 64'd0);
    check("nolink_rate", 64'(bist_gen_rate), 64'd20);

    // Abort in RUN plus an ignored second start in WAIT_LOCK
    g0 = gen_tot; c0 = chkr_tot;
    do_run(0, 6, 2, 4, 50, 0, 6'd33, 1'b1, 1'b1);
    check("abort_result", 64'(result), 64'd5);
    check("abort_gen_cycles", 64'(gen_tot - g0), 64'd11);
    check("abort_chk_cycles", 64'(chkr_tot - c0), 64'd19);
    check("abort_run_count", 64'(run_count), 64'd8);

    // Reset mid-DRAIN, then a clean run
    d0 = done_tot;
    do_run(0, 3, 3, 3, 40, 0, 6'd44, 1'b1, 1'b0);
    check("rst_done", 64'(done_tot - d0), 64'd0);
    check("rst_run_count", 64'(run_count), 64'd0);
    check("rst_rate", 64'(bist_gen_rate), 64'd0);
    do_run(0, 4, 0, 0, 300, 0, 6'd60, 1'b0, 1'b0);
    check("post_rst_result", 64'(result), 64'd0);
    check("post_rst_run_count", 64'(run_count), 64'd1);
    check("post_rst_samps", 64'(samps_latched), 64'd300);

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/aurora_bist_sequencer.md
Name: aurora_bist_sequencer

Overview:
Sequences one complete PRBS BIST run on an Aurora link MAC so that software or a bench issues a single start pulse instead of hand-timing the enables. Per run it:
- arms the rate and the remote loopback select;
- enables generator and checker, then waits for checker lock under a timeout;
- runs for a fixed window and samples the checker sample/error counters;
- disables the generator, drains in-flight data, then disables the checker;
- reports a result code.
It sits beside the link MAC in the sys/user clock domain and drives the MAC BIST control inputs directly.

Parameters:
LOCK_TIMEOUT, 4096, cycles allowed in WAIT_LOCK before failing (must be >=2)
RUN_CYCLES, 512, cycles in RUN after lock before sampling counters (>=1)
DRAIN_CYCLES, 256, cycles in DRAIN with generator off and checker on (>=1)
MIN_SAMPS, 256, bist_samps must be strictly greater than this to pass
CNT_W, 48, width of MAC checker sample/error counters

Ports:
clk  in  1  single clock; all logic synchronous to rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  one-cycle request to begin a run; ignored while busy
abort  in  1  level; terminates an active run
rate  in  6  generator rate, captured on accepted start
remote_loop  in  1  far-end loopback select, captured on accepted start
channel_up  in  1  link status from PHY
bist_locked  in  1  checker lock from MAC
bist_samps  in  CNT_W  checker sample count
bist_errors  in  CNT_W  checker error count
bist_gen_en  out  1  generator enable to MAC
bist_checker_en  out  1  checker enable to MAC
bist_gen_rate  out  6  rate to MAC
bist_loopback_en  out  1  far-end loopback enable
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when a run ends
result  out  3  0 pass, 1 lock timeout, 2 low samples, 3 bit errors, 4 link down, 5 aborted; held until next accepted start
samps_latched  out  CNT_W  bist_samps captured in EVAL
errors_latched  out  CNT_W  bist_errors captured in EVAL
run_count  out  16  completed runs (any result), saturates at 16'hFFFF

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (rst_n=0 at a clk edge): state IDLE and all outputs 0, including result, latched counters and run_count. Reset mid-run drops every enable on that edge and emits no done pulse.
- IDLE:
  - start=1 with channel_up=1: capture rate and remote_loop; go to ARM; result cleared to 0.
  - start=1 with channel_up=0: go to FINISH with result=4.
- ARM (1 cycle): bist_gen_rate and bist_loopback_en driven from the captured values. Next state WAIT_LOCK.
- WAIT_LOCK: bist_gen_en=bist_checker_en=1. The first cycle with gen_en=1 is 2 cycles after the start cycle. A cycle counter starts at 0.
  - bist_locked=1: go to RUN.
  - Counter reaches LOCK_TIMEOUT-1 without lock: result=1, go to DRAIN.
- RUN: enables held. Exactly RUN_CYCLES cycles, then EVAL.
- EVAL (1 cycle): latch samps/errors. Result evaluated in priority order:
  - bist_errors!=0 gives 3;
  - else bist_samps<=MIN_SAMPS gives 2;
  - else 0.
  Next state DRAIN.
- DRAIN: bist_gen_en=0, bist_checker_en=1 for DRAIN_CYCLES cycles, then FINISH.
- FINISH (1 cycle): checker_en=0, loopback_en=0, done=1, run_count increments unless saturated. Next state IDLE.
- Link loss or abort, checked every cycle in ARM, WAIT_LOCK, RUN, EVAL and DRAIN, highest priority first:
  - channel_up=0: result=4, go to FINISH with gen/checker/loopback forced 0 on the next edge; no drain.
  - else abort=1: result=5, go to DRAIN with gen_en=0 and the drain completing normally.
  - If abort and a timeout or EVAL occur on the same cycle, abort wins. Abort in FINISH is ignored.
- bist_gen_rate holds its last captured value in IDLE. Enables never go high in IDLE.
- A latched result is never overwritten by a later condition within the same run, except by link loss (4).

Test Plan:
Use RUN_CYCLES=16, LOCK_TIMEOUT=32, DRAIN_CYCLES=8, MIN_SAMPS=8.
- Nominal: start with rate=60 and channel_up=1; lock asserted 5 cycles after gen_en; samps=100, errors=0 at EVAL -> gen_en high for 5+16+1 cycles, checker_en turns off 8 cycles after gen_en, done pulses once, result=0, samps_latched=100, run_count=1.
- Lock timeout: bist_locked held 0 -> gen_en drops after exactly 32 WAIT_LOCK cycles, 8-cycle drain follows, result=1.
- Errors and low samples: errors=3, samps=2 -> result=3. Then errors=0, samps=8 -> result=2. Then samps=9 -> result=0.
- Link drop: channel_up=0 mid-RUN -> all enables 0 on the next edge, done the cycle after, result=4. Start with channel_up=0 -> done 1 cycle later, result=4, enables never high.
- Abort, and start while busy: abort in RUN -> result=5 after an 8-cycle drain. A second start pulse during WAIT_LOCK is ignored (run_count advances by exactly 1).
- Reset mid-DRAIN: rst_n=0 for one cycle -> all outputs 0 on that edge, no done pulse. A new start then runs normally with run_count starting at 0.
